bitrev_reorder: RTL and testbench

Parametrised bit-reversal reorder buffer for the FFT output path. It accepts complex samples in bit-reversed order, one frame of N = 2^LOG2N samples at a time, and emits them in natural order. Two banks operate ping-pong, so one frame is written while the previous one drains, giving gapless streaming. It adds a per-frame bypass mode, input ready, output valid/ready backpressure, a frame-last marker and a sticky overflow flag.

---
 rtl/bitrev_reorder_if.sv | 27 ++
 rtl/bitrev_reorder.sv | 132 +++++++++++++
 tb/tb_bitrev_reorder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bitrev_reorder_if.sv
// Stream bundle for the bit-reversal reorder buffer: sample input with ready,
// sample output with valid/ready and frame-last, plus the sticky overflow flag.
interface bitrev_reorder_if #(
  parameter int WIDTH = 18
);
  logic signed [WIDTH-1:0] di_re;
  logic signed [WIDTH-1:0] di_im;
  logic                    di_en;
  logic                    di_bypass;
  logic                    di_rdy;
  logic signed [WIDTH-1:0] do_re;
  logic signed [WIDTH-1:0] do_im;
  logic                    do_en;
  logic                    do_last;
  logic                    do_rdy;
  logic                    ovf;

  modport slave (
    input  di_re, di_im, di_en, di_bypass, do_rdy,
    output di_rdy, do_re, do_im, do_en, do_last, ovf
  );

  modport master (
    output di_re, di_im, di_en, di_bypass, do_rdy,
    input  di_rdy, do_re, do_im, do_en, do_last, ovf
  );
endinterface

// File: rtl/bitrev_reorder.sv
// Ping-pong bit-reversal reorder buffer: frames arrive in bit-reversed order and
// leave in natural order, one sample per cycle each side, with per-frame bypass.
module bitrev_reorder #(
  parameter int WIDTH = 18,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst,
  bitrev_reorder_if.slave  io
);
  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } sample_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  // Both banks share one array; the bank bit is the address MSB.
  sample_t mem [2*N];

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]       full_q, full_d;
  logic             byp_q, byp_d;
  logic             do_en_q, do_en_d;
  logic             do_last_q, do_last_d;
  sample_t          do_q, do_d;
  logic             ovf_q, ovf_d;

  logic             wr_rdy;
  logic             wr_acc;
  logic             wr_byp;
  logic [LOG2N-1:0] wr_addr;
  logic             adv;

  assign wr_rdy  = !full_q[wr_bank_q];
  assign wr_acc  = io.di_en && wr_rdy;
  // The first sample of a frame already honours the bypass it presents.
  assign wr_byp  = (wr_cnt_q == '0) ? io.di_bypass : byp_q;
  assign wr_addr = wr_byp ? wr_cnt_q : bitrev(wr_cnt_q);
  assign adv     = !do_en_q || io.do_rdy;

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    full_d    = full_q;
    byp_d     = byp_q;
    do_en_d   = do_en_q;
    do_last_d = do_last_q;
    do_d      = do_q;
    ovf_d     = ovf_q;

    if (io.di_en && !wr_rdy) ovf_d = 1'b1;

    if (wr_acc) begin
      if (wr_cnt_q == '0) byp_d = io.di_bypass;
      wr_cnt_d = wr_cnt_q + ONE;
      if (wr_cnt_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    // The writer never targets a full bank, so this clear never collides
    // with the set above on the same bank.
    if (adv) begin
      if (full_q[rd_bank_q]) begin
        do_d      = mem[{rd_bank_q, rd_cnt_q}];
        do_en_d   = 1'b1;
        do_last_d = (rd_cnt_q == LAST);
        rd_cnt_d  = rd_cnt_q + ONE;
        if (rd_cnt_q == LAST) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
        end
      end else begin
        do_d      = '0;
        do_en_d   = 1'b0;
        do_last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wr_bank_q, wr_addr}] <= '{re: io.di_re, im: io.di_im};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      full_q    <= '0;
      byp_q     <= 1'b0;
      do_en_q   <= 1'b0;
      do_last_q <= 1'b0;
      do_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
      byp_q     <= byp_d;
      do_en_q   <= do_en_d;
      do_last_q <= do_last_d;
      do_q      <= do_d;
      ovf_q     <= ovf_d;
    end
  end

  assign io.di_rdy  = wr_rdy;
  assign io.do_re   = do_q.re;
  assign io.do_im   = do_q.im;
  assign io.do_en   = do_en_q;
  assign io.do_last = do_last_q;
  assign io.ovf     = ovf_q;
endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed bench: N=8 instance for ordering, timing, bypass, backpressure and
// reset; N=16 instance for the larger bit-reverse map.
module tb_bitrev_reorder;
  localparam int WIDTH = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bitrev_reorder_if #(.WIDTH(WIDTH)) ifa ();
  bitrev_reorder_if #(.WIDTH(WIDTH)) ifb ();

  bitrev_reorder #(.WIDTH(WIDTH), .LOG2N(3)) ua (.clk(clk), .rst(rst), .io(ifa));
  bitrev_reorder #(.WIDTH(WIDTH), .LOG2N(4)) ub (.clk(clk), .rst(rst), .io(ifb));

  typedef struct {
    int re;
    int im;
    bit last;
    int cyc;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];
  int   cyc = 0;
  int   last_acc = 0;
  int   rdy_low = 0;
  int   checks = 0;
  int   errs = 0;

  int br8 [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int br16 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.do_en && ifa.do_rdy)
        qa.push_back('{int'(ifa.do_re), int'(ifa.do_im), ifa.do_last, cyc});
      if (ifb.do_en && ifb.do_rdy)
        qb.push_back('{int'(ifb.do_re), int'(ifb.do_im), ifb.do_last, cyc});
      if (ifa.di_en && ifa.di_rdy) last_acc = cyc;
      if (ifa.di_en && !ifa.di_rdy) rdy_low++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input integer got, input integer exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_a(input int re0, input int im0, input bit byp, input int n);
    for (int j = 0; j < n; j++) begin
      ifa.di_en     = 1'b1;
      ifa.di_re     = WIDTH'(re0 + j);
      ifa.di_im     = WIDTH'(im0 + j);
      ifa.di_bypass = byp;
      tick();
    end
    ifa.di_en     = 1'b0;
    ifa.di_bypass = 1'b0;
  endtask

  // Expected output k of a reordered frame is input sample br8[k].
  task automatic check_frame_a(input string tag, input int off, input bit byp,
                               input int re0, input int im0);
    int idx;
    if (qa.size() >= off + 8) begin
      for (int k = 0; k < 8; k++) begin
        idx = byp ? k : br8[k];
        chk($sformatf("%s_re%0d", tag, k), qa[off+k].re, re0 + idx);
        chk($sformatf("%s_im%0d", tag, k), qa[off+k].im, im0 + idx);
        chk($sformatf("%s_last%0d", tag, k), qa[off+k].last, (k == 7) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int gaps;
    ifa.di_en = 0; ifa.di_re = '0; ifa.di_im = '0; ifa.di_bypass = 0; ifa.do_rdy = 1;
    ifb.di_en = 0; ifb.di_re = '0; ifb.di_im = '0; ifb.di_bypass = 0; ifb.do_rdy = 1;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_do_en", ifa.do_en, 0);
    chk("rst_do_last", ifa.do_last, 0);
    chk("rst_do_re", ifa.do_re, 0);
    chk("rst_di_rdy", ifa.di_rdy, 1);
    chk("rst_ovf", ifa.ovf, 0);

    // Single frame: order, latency and drain length.
    qa.delete();
    send_a(0, 100, 0, 8);
    repeat (12) tick();
    chk("f1_count", qa.size(), 8);
    check_frame_a("f1", 0, 0, 0, 100);
    if (qa.size() == 8) begin
      chk("f1_latency", qa[0].cyc - last_acc, 2);
      chk("f1_span", qa[7].cyc - qa[0].cyc, 7);
    end

    // Three back-to-back frames, bypass on the middle one.
    qa.delete();
    rdy_low = 0;
    send_a(0, 10, 0, 8);
    send_a(0, 20, 1, 8);
    send_a(0, 30, 0, 8);
    repeat (12) tick();
    chk("b2b_count", qa.size(), 24);
    check_frame_a("b2b1", 0, 0, 0, 10);
    check_frame_a("b2b2", 8, 1, 0, 20);
    check_frame_a("b2b3", 16, 0, 0, 30);
    gaps = 0;
    for (int i = 1; i < qa.size(); i++) if (qa[i].cyc != qa[i-1].cyc + 1) gaps++;
    chk("b2b_gaps", gaps, 0);
    chk("b2b_rdy_low", rdy_low, 0);
    chk("b2b_ovf", ifa.ovf, 0);

    // Backpressure: both banks fill, the 17th sample is dropped.
    ifa.do_rdy = 1'b0;
    send_a(0, 50, 0, 8);
    send_a(8, 60, 0, 8);
    chk("bp_rdy_low", ifa.di_rdy, 0);
    ifa.di_en = 1'b1; ifa.di_re = WIDTH'(99); ifa.di_im = WIDTH'(99);
    tick();
    ifa.di_en = 1'b0;
    chk("bp_ovf", ifa.ovf, 1);
    chk("bp_hold_en", ifa.do_en, 1);
    chk("bp_hold_im", ifa.do_im, 50);
    repeat (4) tick();
    chk("bp_hold_en2", ifa.do_en, 1);
    chk("bp_hold_im2", ifa.do_im, 50);
    chk("bp_hold_last", ifa.do_last, 0);
    qa.delete();
    ifa.do_rdy = 1'b1;
    repeat (20) tick();
    chk("bp_count", qa.size(), 16);
    check_frame_a("bpA", 0, 0, 0, 50);
    check_frame_a("bpB", 8, 0, 8, 60);
    // A fresh frame lines up only if the dropped sample left no trace.
    qa.delete();
    send_a(20, 70, 0, 8);
    repeat (12) tick();
    chk("post_bp_count", qa.size(), 8);
    check_frame_a("post_bp", 0, 0, 20, 70);
    chk("ovf_sticky", ifa.ovf, 1);

    // Reset mid-frame while the previous frame drains.
    send_a(0, 10, 0, 8);
    send_a(0, 20, 0, 5);
    chk("pre_rst_do_en", ifa.do_en, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_do_en", ifa.do_en, 0);
    chk("mid_rst_do_last", ifa.do_last, 0);
    chk("mid_rst_do_re", ifa.do_re, 0);
    chk("mid_rst_do_im", ifa.do_im, 0);
    chk("mid_rst_di_rdy", ifa.di_rdy, 1);
    chk("mid_rst_ovf", ifa.ovf, 0);
    rst = 1'b0;
    qa.delete();
    send_a(0, 40, 0, 8);
    repeat (12) tick();
    chk("post_rst_count", qa.size(), 8);
    check_frame_a("post_rst", 0, 0, 0, 40);

    // N = 16 ordering.
    qb.delete();
    for (int j = 0; j < 16; j++) begin
      ifb.di_en = 1'b1;
      ifb.di_re = WIDTH'(j);
      ifb.di_im = WIDTH'(-j);
      tick();
    end
    ifb.di_en = 1'b0;
    repeat (22) tick();
    chk("n16_count", qb.size(), 16);
    if (qb.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("n16_re%0d", k), qb[k].re, br16[k]);
        chk($sformatf("n16_im%0d", k), qb[k].im, -br16[k]);
        chk($sformatf("n16_last%0d", k), qb[k].last, (k == 15) ? 1 : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
